pool_sched: RTL and testbench
=============================

# pool_sched

Frame-level scheduler that shares one 2x2 max-pooling line buffer between `N_CH` binary feature-map producers (conv channels). It grants one whole `WIDTH`x`HEIGHT` frame at a time in round-robin order and forwards that frame's pixels to the pooling buffer. It then counts the pooled windows coming back and signals frame completion with the channel id. It sits between the conv channel outputs and the pooling buffer / pooled-result consumer.

## Interface
Parameters:
- `N_CH`, 4: number of requesting channels, >= 1.
- `WIDTH`, 26: frame width in pixels, even, >= 2.
- `HEIGHT`, 26: frame height in pixels, even, >= 2.
- `TIMEOUT`, 1024: stall limit in cycles for the watchdog, >= 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_CH`: channel c has a pixel available.
- `req_pixel` in `N_CH`: binary pixel of channel c.
- `req_ready` out `N_CH`: one-hot or zero; pixel of channel c is accepted when `req_valid[c] & req_ready[c]`.
- `buf_valid_in` out 1: pixel strobe to the pooling buffer (`valid_in`).
- `buf_pixel_in` out 1: pixel to the pooling buffer.
- `buf_valid_out` in 1: pooled-window strobe from the pooling buffer.
- `grant_id` out `max(1,$clog2(N_CH))`: channel currently owning the buffer.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse when a frame has completed.
- `done_id` out `max(1,$clog2(N_CH))`: channel of the completed frame; valid with `frame_done`.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- **IDLE**
  - If any `req_valid` is set, pick the first set channel at or after `rr_ptr`, wrapping.
  - Load `grant_id`, go to STREAM.
  - Otherwise stay in IDLE.
- **STREAM**
  - `req_ready[grant_id]=1`.
  - On each handshake, register the pixel: next cycle `buf_valid_in=1` and `buf_pixel_in=req_pixel[grant_id]`. Otherwise `buf_valid_in=0`.
  - `pix_cnt` counts accepted pixels, 0 to `WIDTH*HEIGHT-1`.
  - On the handshake with `pix_cnt==WIDTH*HEIGHT-1`, deassert `req_ready` from the next cycle and go to DRAIN.
- **Pooled-output counting**
  - `out_cnt` counts `buf_valid_out` in STREAM and DRAIN.
  - Expected count `N_OUT=(WIDTH/2)*(HEIGHT/2)`.
- **DRAIN**
  - When `out_cnt` reaches `N_OUT` (including the strobe arriving this cycle), go to DONE.
- **DONE**
  - Pulse `frame_done`, with `done_id=grant_id`.
  - Set `rr_ptr=grant_id+1`, wrapping at `N_CH`.
  - Clear both counters and go to IDLE.
- `busy=1` in STREAM, DRAIN and DONE.
- Pixel ordering is raster order. The buffer's coordinates wrap on its own at frame end, so no buffer reset is issued between frames.
- Requests from non-granted channels are held off (`req_ready=0`) until their turn. A requester dropping `req_valid` mid-frame only stalls the frame; the grant is kept.
- `buf_valid_out` seen in IDLE is ignored.
- Counter widths: `$clog2(WIDTH*HEIGHT)` and `$clog2(N_OUT+1)`.

## Timing
- Reset values: `req_ready=0`, `buf_valid_in=0`, `buf_pixel_in=0`, `grant_id=0`, `busy=0`, `frame_done=0`, `done_id=0`, `err_timeout=0`, `rr_ptr=0`, state IDLE.
- Arbitration latency: 1 cycle. `req_ready` rises the cycle after IDLE sees `req_valid`.
- Forward latency: 1 cycle from handshake to `buf_valid_in`.
- The pooling buffer returns a window 2 cycles after the `buf_valid_in` carrying the odd-x/odd-y pixel. The last window therefore arrives 3 cycles after the last handshake.
- `frame_done` fires 1 cycle after the final `buf_valid_out`.
- Minimum frame period: `WIDTH*HEIGHT+5` cycles.
- Back-to-back frames from different channels need no idle gap beyond IDLE's one cycle.
- Reset asserted mid-frame aborts the frame immediately. All state returns to reset values. The pooling buffer shares `rst_n`, so both restart aligned.

## Configuration
- Macro `POOL_SCHED_TIMEOUT_EN`.
- **Defined:** a stall counter runs in STREAM and DRAIN.
  - It increments on any cycle without a handshake (STREAM) or without `buf_valid_out` (DRAIN), and clears on progress.
  - On reaching `TIMEOUT`, `err_timeout` sets and stays set until reset. The FSM continues unchanged.
- **Undefined:** no stall counter is built; `err_timeout` is tied to 0.

## Structure
- Package `pool_sched_pkg` holds:
  - the FSM state enum (`IDLE`, `STREAM`, `DRAIN`, `DONE`);
  - a localparam-computing function for `N_OUT`;
  - the channel-id width helper.
- Sub-module `rr_arbiter`: combinational round-robin pick of `N_CH` requests given `rr_ptr`. It returns a one-hot grant and a binary index.

## Test plan
- **Single frame:** `N_CH=4`, `WIDTH=HEIGHT=4`, ch2 streams 16 pixels continuously -> `grant_id=2`, 16 `buf_valid_in`, 4 `buf_valid_out` counted, `frame_done` with `done_id=2` 4 cycles after the last handshake.
- **Round-robin:** ch0 and ch3 request together at reset -> ch0 frame first, then ch3. Then ch0 and ch1 request -> ch1 before ch0.
- **Stalls:** granted channel drops `req_valid` for 5 cycles mid-frame -> `req_ready` stays high, `buf_valid_in` has a 5-cycle gap, `frame_done` is still reached with a correct 4-window count.
- **Reset mid-frame:** `rst_n` low after 7 pixels -> all outputs at reset values. The next frame after release completes normally with 4 windows.
- **Watchdog:** with `POOL_SCHED_TIMEOUT_EN`, `TIMEOUT=8`, stall for 8 cycles -> `err_timeout=1` and it stays set after the frame completes. Without the macro the same stimulus gives `err_timeout=0`.

Source files
------------

// File: rtl/pool_sched_pkg.sv
// Shared types and sizing helpers for the pool_sched frame scheduler.
package pool_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of 2x2 windows the pooling buffer emits for one frame.
    function automatic int n_out(input int width, input int height);
        return (width / 2) * (height / 2);
    endfunction

    function automatic int id_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/pool_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
    import pool_sched_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]           req,
    input  logic [id_w(N_CH)-1:0]     ptr,
    output logic [N_CH-1:0]           grant,
    output logic [id_w(N_CH)-1:0]     idx
);

    localparam int IDW = id_w(N_CH);

    logic [N_CH-1:0]           hi_mask;
    logic [N_CH-1:0]           masked;
    logic [N_CH-1:0]           pick_src;
    logic [IDW-1:0][N_CH-1:0]  idx_bits;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
        assign hi_mask[gi] = (gi >= int'(ptr));
    end

    // Prefer requesters at/after ptr; fall back to the lowest one when none are.
    assign masked   = req & hi_mask;
    assign pick_src = (|masked) ? masked : req;
    assign grant    = pick_src & (~pick_src + N_CH'(1));

    for (genvar gb = 0; gb < IDW; gb++) begin : g_idx_bit
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_idx_ch
            assign idx_bits[gb][gi] = grant[gi] & (((gi >> gb) & 1) != 0);
        end
        assign idx[gb] = |idx_bits[gb];
    end

endmodule

// File: rtl/pool_sched.sv
// Round-robin frame scheduler feeding a shared 2x2 max-pooling line buffer.
// Optional stall watchdog enabled by defining POOL_SCHED_TIMEOUT_EN.
module pool_sched
    import pool_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 26,
    parameter int HEIGHT  = 26,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           req_valid,
    input  logic [N_CH-1:0]           req_pixel,
    output logic [N_CH-1:0]           req_ready,
    output logic                      buf_valid_in,
    output logic                      buf_pixel_in,
    input  logic                      buf_valid_out,
    output logic [id_w(N_CH)-1:0]     grant_id,
    output logic                      busy,
    output logic                      frame_done,
    output logic [id_w(N_CH)-1:0]     done_id,
    output logic                      err_timeout
);

    localparam int IDW   = id_w(N_CH);
    localparam int N_OUT = n_out(WIDTH, HEIGHT);
    localparam int PW    = $clog2(WIDTH * HEIGHT);
    localparam int OW    = $clog2(N_OUT + 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(WIDTH * HEIGHT - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT);

    state_t          state_reg;
    logic [IDW-1:0]  rr_ptr_reg;
    logic [PW-1:0]   pix_cnt_reg;
    logic [OW-1:0]   out_cnt_reg;
    logic [OW-1:0]   out_cnt_next;
    logic [N_CH-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic [IDW-1:0]  rr_ptr_next;
    logic            hs;
    logic            hs_pixel;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // req_ready is one-hot on the granted channel, so masking avoids a dynamic index.
    assign hs           = |(req_valid & req_ready);
    assign hs_pixel     = |(req_pixel & req_ready);
    assign out_cnt_next = out_cnt_reg + OW'(buf_valid_out);
    assign rr_ptr_next  = (grant_id == IDW'(N_CH - 1)) ? '0 : grant_id + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            pix_cnt_reg  <= '0;
            out_cnt_reg  <= '0;
            req_ready    <= '0;
            buf_valid_in <= 1'b0;
            buf_pixel_in <= 1'b0;
            grant_id     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            done_id      <= '0;
        end else begin
            buf_valid_in <= 1'b0;
            frame_done   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id  <= arb_idx;
                        req_ready <= arb_grant;
                        busy      <= 1'b1;
                        state_reg <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        buf_valid_in <= 1'b1;
                        buf_pixel_in <= hs_pixel;
                        pix_cnt_reg  <= pix_cnt_reg + PW'(1);
                        if (pix_cnt_reg == PIX_LAST) begin
                            req_ready <= '0;
                            state_reg <= DRAIN;
                        end
                    end
                    out_cnt_reg <= out_cnt_next;
                end
                DRAIN: begin
                    out_cnt_reg <= out_cnt_next;
                    if (out_cnt_next == OUT_LAST) begin
                        frame_done <= 1'b1;
                        done_id    <= grant_id;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr_reg  <= rr_ptr_next;
                    pix_cnt_reg <= '0;
                    out_cnt_reg <= '0;
                    busy        <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef POOL_SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall_cnt_reg;
    logic          counting;
    logic          progress;

    assign counting = (state_reg == STREAM) || (state_reg == DRAIN);
    assign progress = (state_reg == STREAM) ? hs : buf_valid_out;

    // Purely observational: the FSM keeps running after the flag sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            err_timeout   <= 1'b0;
        end else begin
            if (!counting || progress) begin
                stall_cnt_reg <= '0;
            end else if (stall_cnt_reg != SW'(TIMEOUT)) begin
                stall_cnt_reg <= stall_cnt_reg + SW'(1);
            end
            if (counting && !progress && (stall_cnt_reg == SW'(TIMEOUT - 1))) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pool_sched.sv
// Directed bench for pool_sched with a small behavioural model of the pooling buffer.
module tb_pool_sched;

    localparam int N_CH = 4;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int TO   = 8;
    localparam int NPIX = W * H;

`ifdef POOL_SCHED_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] req_valid = '0;
    logic [N_CH-1:0] req_pixel = '0;
    logic [N_CH-1:0] req_ready;
    logic            buf_valid_in;
    logic            buf_pixel_in;
    logic            buf_valid_out;
    logic [1:0]      grant_id;
    logic            busy;
    logic            frame_done;
    logic [1:0]      done_id;
    logic            err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pool_sched #(.N_CH(N_CH), .WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_pixel     (req_pixel),
        .req_ready     (req_ready),
        .buf_valid_in  (buf_valid_in),
        .buf_pixel_in  (buf_pixel_in),
        .buf_valid_out (buf_valid_out),
        .grant_id      (grant_id),
        .busy          (busy),
        .frame_done    (frame_done),
        .done_id       (done_id),
        .err_timeout   (err_timeout)
    );

    // Pooling buffer model: window strobe 2 cycles after the odd-x/odd-y pixel.
    int   mx;
    int   my;
    logic win_d1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx <= 0; my <= 0; win_d1 <= 1'b0; buf_valid_out <= 1'b0;
        end else begin
            win_d1        <= buf_valid_in && mx[0] && my[0];
            buf_valid_out <= win_d1;
            if (buf_valid_in) begin
                if (mx == W - 1) begin
                    mx <= 0;
                    my <= (my == H - 1) ? 0 : my + 1;
                end else begin
                    mx <= mx + 1;
                end
            end
        end
    end

    // Monitor: counts handshakes, forwarded pixels, windows and pixel gaps.
    int          cyc = 0;
    int          hs_cnt = 0;
    int          last_hs_cyc = 0;
    int          vin_cnt = 0;
    int          vout_cnt = 0;
    int          run = 0;
    int          max_gap = 0;
    int          fd_lat = 0;
    logic [15:0] pix_word = '0;
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (|(req_valid & req_ready)) begin
                hs_cnt++;
                last_hs_cyc = cyc - 1;
            end
            if (buf_valid_in) begin
                if (vin_cnt > 0 && run > max_gap) max_gap = run;
                run = 0;
                if (vin_cnt < 16) pix_word[vin_cnt[3:0]] = buf_pixel_in;
                vin_cnt++;
            end else if (vin_cnt > 0) begin
                run++;
            end
            if (buf_valid_out) vout_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        vin_cnt = 0; vout_cnt = 0; run = 0; max_gap = 0; pix_word = '0;
    endtask

    task automatic send_frame(input int ch, input logic [15:0] pat, input int npix,
                              input int stall_at, input int stall_len);
        int base;
        int sent;
        int stalled;
        int cycles;
        base = hs_cnt; stalled = 0; cycles = 0;
        req_valid[ch] = 1'b1;
        req_pixel[ch] = pat[0];
        while (cycles < 300) begin
            @(negedge clk);
            cycles++;
            sent = hs_cnt - base;
            if (sent >= npix) break;
            if (sent == stall_at && stalled < stall_len) begin
                req_valid[ch] = 1'b0;
                stalled++;
                check("stall_ready_held", 32'(req_ready[ch]), 32'd1);
            end else begin
                req_valid[ch] = 1'b1;
                req_pixel[ch] = pat[sent[3:0]];
            end
        end
        req_valid[ch] = 1'b0;
        check("handshakes", hs_cnt - base, npix);
    endtask

    task automatic wait_done(input int exp_id);
        int n;
        n = 0;
        while (!frame_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        fd_lat = cyc - last_hs_cyc;
        check("frame_done_seen", 32'(frame_done), 32'd1);
        check("done_id", 32'(done_id), exp_id);
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_buf_valid_in", 32'(buf_valid_in), 32'd0);
        check("rst_buf_pixel_in", 32'(buf_pixel_in), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req_busy", 32'(busy), 32'd0);

        // Round-robin: ch0 and ch3 together -> ch0 then ch3
        req_valid = 4'b1001;
        @(negedge clk);
        check("rr_a_grant", 32'(grant_id), 32'd0);
        check("rr_a_ready", 32'(req_ready), 32'h1);
        check("rr_a_busy", 32'(busy), 32'd1);
        clear_mon();
        send_frame(0, 16'h1234, NPIX, -1, 0);
        wait_done(0);
        check("rr_a_vin", vin_cnt, 16);
        check("rr_a_vout", vout_cnt, 4);
        check("rr_a_pixels", 32'(pix_word), 32'h1234);
        @(negedge clk);
        check("rr_b_grant", 32'(grant_id), 32'd3);
        check("rr_b_ready", 32'(req_ready), 32'h8);
        clear_mon();
        send_frame(3, 16'hFFFF, NPIX, -1, 0);
        wait_done(3);
        check("rr_b_vout", vout_cnt, 4);
        check("rr_b_pixels", 32'(pix_word), 32'hFFFF);

        // Stall: ch0 drops valid for 5 cycles after 6 pixels
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("stall_grant", 32'(grant_id), 32'd0);
        clear_mon();
        send_frame(0, 16'h0F0F, NPIX, 6, 5);
        wait_done(0);
        check("stall_gap", max_gap, 5);
        check("stall_vin", vin_cnt, 16);
        check("stall_vout", vout_cnt, 4);
        check("stall_pixels", 32'(pix_word), 32'h0F0F);
        check("stall_no_err", 32'(err_timeout), 32'd0);

        // Round-robin: rr_ptr now 1, so ch1 beats ch0
        req_valid = 4'b0011;
        @(negedge clk);
        check("rr_c_grant", 32'(grant_id), 32'd1);
        check("rr_c_ready", 32'(req_ready), 32'h2);
        clear_mon();
        send_frame(1, 16'hA5A5, NPIX, -1, 0);
        wait_done(1);
        check("rr_c_vout", vout_cnt, 4);
        @(negedge clk);
        check("rr_d_grant", 32'(grant_id), 32'd0);
        clear_mon();
        send_frame(0, 16'h8001, NPIX, -1, 0);
        wait_done(0);
        check("rr_d_pixels", 32'(pix_word), 32'h8001);

        // Single frame on ch2, latency of frame_done from last handshake
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("single_grant", 32'(grant_id), 32'd2);
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_busy", 32'(busy), 32'd1);
        clear_mon();
        send_frame(2, 16'hC3A5, NPIX, -1, 0);
        wait_done(2);
        check("single_done_latency", fd_lat, 4);
        check("single_vin", vin_cnt, 16);
        check("single_vout", vout_cnt, 4);
        check("single_gap", max_gap, 0);
        check("single_pixels", 32'(pix_word), 32'hC3A5);

        // Reset mid-frame after 7 pixels on ch1
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("mid_grant", 32'(grant_id), 32'd1);
        send_frame(1, 16'hFFFF, 7, -1, 0);
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_vin", 32'(buf_valid_in), 32'd0);
        check("mid_rst_pix", 32'(buf_pixel_in), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        check("post_rst_grant", 32'(grant_id), 32'd1);
        req_valid[3] = 1'b0;
        clear_mon();
        send_frame(1, 16'h5A5A, NPIX, -1, 0);
        wait_done(1);
        check("post_rst_vin", vin_cnt, 16);
        check("post_rst_vout", vout_cnt, 4);
        check("post_rst_pixels", 32'(pix_word), 32'h5A5A);

        // Watchdog: 8-cycle stall on ch2
        check("wd_err_before", 32'(err_timeout), 32'd0);
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("wd_grant", 32'(grant_id), 32'd2);
        clear_mon();
        send_frame(2, 16'h3C3C, NPIX, 4, 8);
        wait_done(2);
        check("wd_vout", vout_cnt, 4);
        check("wd_err_after_frame", 32'(err_timeout), 32'(EXP_ERR));
        repeat (3) @(negedge clk);
        check("wd_err_sticky", 32'(err_timeout), 32'(EXP_ERR));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
